hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline control unit for the five-stage RV32IM core. Each cycle it computes the `stalls` and `flushes` vectors consumed by every stage register through `pipeline_i`, covering load-use interlock, branch/jump redirect and memory wait. It also sequences the multi-cycle RV32M unit, holding the instruction in E until the result is ready. It sits beside the datapath and owns no architectural state.

## Interface
Parameters:
- `MUL_CYCLES`, 4: E-stage occupancy of MUL/MULH/MULHSU/MULHU. Range 1..63.
- `DIV_CYCLES`, 33: E-stage occupancy of DIV/DIVU/REM/REMU. Range 1..63.

Ports:
- `clk`  in  1  core clock
- `rst_n`  in  1  reset; asynchronous, active-low
- `d_rs1`, `d_rs2`  in  5 each  source registers of the instruction in D
- `e_rd`  in  5  destination register of the instruction in E
- `e_l`  in  1  instruction in E is a load
- `e_m`  in  1  instruction in E is an RV32M op
- `e_func3`  in  3  func3 of the instruction in E; bit 2 set means divide/remainder
- `redirect`  in  1  taken branch/jump resolved in E
- `mem_wait`  in  1  data memory not ready in M
- `stalls`  out  5  per-stage hold, indexed by the stage enum F,D,E,M,W = 0..4
- `flushes`  out  5  per-stage bubble insert
- `mdu_start`  out  1  one-cycle pulse that launches an M op
- `mdu_done`  out  1  the E/M register captures the M result this cycle

## Operation
Stage register semantics:
- `stalls[s]` makes stage s hold its output register.
- `flushes[s]` makes stage s load zeros into its output register.
- Flush overrides stall.

Sources, in priority order (highest first):
- **Redirect:** `flushes[F]` = 1 and `flushes[D]` = 1. If `e_m` is also set, the M op is aborted: FSM goes to IDLE, and neither `mdu_start` nor `mdu_done` is asserted.
- **Memory wait:** `stalls[F..M]` = 1 and `flushes[M]` = 1. The FSM counter keeps decrementing but cannot leave BUSY while `mem_wait` = 1.
- **M busy:** `stalls[F]` = 1, `stalls[D]` = 1 and `flushes[E]` = 1. The M instruction stays in the D/E register and bubbles go to M.
- **Load-use:** asserted when `e_l`, `e_rd` != 0, and `e_rd` equals `d_rs1` or `d_rs2`. Response is `stalls[F]` = 1 and `flushes[D]` = 1, giving exactly one bubble.

Redirect and M-busy both act on the same E instruction. Memory wait and M-busy do not conflict: their stall terms are OR-ed and their flush terms are OR-ed.

M FSM:
- Latency: lat = `DIV_CYCLES` if `e_func3[2]` = 1, else `MUL_CYCLES`.
- **IDLE:** when `e_m` = 1 and there is no redirect, pulse `mdu_start`, assert the M-busy terms, load cnt = lat−1, and go to BUSY.
- **BUSY, cnt != 0:** assert the M-busy terms and decrement cnt.
- **BUSY, cnt = 0:** no M-busy terms. If `mem_wait` = 0, `mdu_done` = 1 and go to IDLE. Otherwise stay in BUSY with cnt held at 0.
- Result: the M-busy terms are asserted for exactly lat cycles, followed by one done cycle.
- The done cycle lets D/E advance. The next IDLE cycle therefore sees a new instruction, so back-to-back M ops both start.
- Counter cnt is 6 bits and saturates at 0; it never wraps.

## Timing
- `stalls`, `flushes`, `mdu_start` and `mdu_done` are combinational from the inputs plus state/cnt, with zero-cycle latency.
- Only state and cnt are registered.
- Reset: state = IDLE and cnt = 0, so every output is 0 when all inputs are 0.
- Asserting `rst_n` mid-op aborts immediately with no done pulse.
- Load-use costs 1 cycle, redirect costs 2 cycles, and an M op costs lat cycles.

## Configuration
`HAZARD_FAST_MUL_EN`:
- **Defined:** multiplies take 0 extra cycles. `mdu_start` and `mdu_done` pulse in the same IDLE cycle, no stall is generated, and the FSM does not leave IDLE. `MUL_CYCLES` is ignored. Divides are unchanged.
- **Undefined:** multiplies follow `MUL_CYCLES` as described above.

## Structure
- Shared `defs` package holds:
  - the stage enum F/D/E/M/W;
  - the `mdu_state_t` enum {IDLE, BUSY};
  - localparam `MDU_CNT_W` = 6.
- One sub-module, `mdu_seq`, containing the FSM and counter. Inputs are `e_m`, `e_func3`, `redirect` and `mem_wait`; outputs are busy, `mdu_start` and `mdu_done`.
- The priority merge stays in `hazard_ctrl`.

## Test plan
- **Load-use:** `e_l` = 1, `e_rd` = 5, `d_rs2` = 5 → one cycle with `stalls` = 5'b00001 and `flushes` = 5'b00010. With `e_rd` = 0 → all zero.
- **Redirect:** `redirect` = 1 for one cycle → `flushes` = 5'b00011 and `stalls` = 0 that cycle only. With load-use also true → same result.
- **DIV:** `e_m` = 1, `e_func3` = 3'b100, `DIV_CYCLES` = 33 → `mdu_start` at cycle 0, `stalls[F:D]` and `flushes[E]` high for cycles 0–32, `mdu_done` at cycle 33. Two back-to-back DIVs → second `mdu_start` at cycle 34.
- **Memory wait during M op:** `mem_wait` high from cycle 30 to 40 during a DIV → `mdu_done` first at cycle 41, and `stalls` = 5'b01111 during the wait.
- **Reset mid-op:** drop `rst_n` at cycle 10 of a DIV → state IDLE with all outputs 0 asynchronously. After release with `e_m` = 0 → no `mdu_done`.
- **Fast multiply:** with `HAZARD_FAST_MUL_EN`, MUL (`e_func3` = 0) → `mdu_start` = `mdu_done` = 1 in one cycle and `stalls` = 0. Without the macro, `MUL_CYCLES` = 4 → 4 stall cycles, then done.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: stage indices,
// multi-cycle unit FSM states and counter width.
// Optional build macro used by this slice: HAZARD_FAST_MUL_EN.
package defs;

   // Stage index into the stalls/flushes vectors
   typedef enum logic [2:0] {
      F = 3'd0,
      D = 3'd1,
      E = 3'd2,
      M = 3'd3,
      W = 3'd4
   } stage_t;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } mdu_state_t;

   localparam int unsigned MDU_CNT_W = 6;

   // Initial counter value for an op: occupancy minus the start cycle
   function automatic logic [MDU_CNT_W-1:0] mdu_cnt_init(
      input logic        is_div,
      input int unsigned mul_cycles,
      input int unsigned div_cycles
   );
      int unsigned lat;
      lat = is_div ? div_cycles : mul_cycles;
      return MDU_CNT_W'(lat - 1);
   endfunction

endpackage

// File: rtl/hazard_ctrl_mdu_seq.sv
// Multi-cycle RV32M sequencer: holds the M instruction in E for its
// latency, then pulses done once memory is ready.
// With HAZARD_FAST_MUL_EN defined, multiplies complete in the start cycle.
import defs::*;

module mdu_seq #(
   parameter int unsigned MUL_CYCLES = 4,
   parameter int unsigned DIV_CYCLES = 33
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       e_m,
   input  logic [2:0] e_func3,
   input  logic       redirect,
   input  logic       mem_wait,
   output logic       busy,
   output logic       mdu_start,
   output logic       mdu_done
);

   mdu_state_t           state, state_d;
   logic [MDU_CNT_W-1:0] cnt, cnt_d;
   logic                 is_div;
   logic                 fast;
   logic                 abort;
   logic                 unused_func3;

   assign is_div       = e_func3[2];
   assign unused_func3 = ^e_func3[1:0];
   // A redirect discards the M instruction sitting in E
   assign abort        = redirect & e_m;

`ifdef HAZARD_FAST_MUL_EN
   assign fast = ~is_div;
`else
   assign fast = 1'b0;
`endif

   // State and counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
      end
   end

   // Next state: count down while busy, leave only when memory is ready
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      unique case (state)
         IDLE: begin
            if (e_m && !redirect && !fast) begin
               state_d = BUSY;
               cnt_d   = mdu_cnt_init(is_div, MUL_CYCLES, DIV_CYCLES);
            end
         end
         BUSY: begin
            if (abort) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt != '0) begin
               cnt_d = cnt - 1'b1;
            end else if (!mem_wait) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs: busy covers the start cycle plus cnt cycles, done follows
   always_comb begin
      busy      = 1'b0;
      mdu_start = 1'b0;
      mdu_done  = 1'b0;
      unique case (state)
         IDLE: begin
            if (e_m && !redirect) begin
               mdu_start = 1'b1;
               if (fast) mdu_done = 1'b1;
               else      busy     = 1'b1;
            end
         end
         BUSY: begin
            if (!abort) begin
               if (cnt != '0)     busy     = 1'b1;
               else if (!mem_wait) mdu_done = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the five-stage RV32IM core: merges
// redirect, memory wait, M-unit busy and load-use into per-stage
// stall/flush vectors. Build macro HAZARD_FAST_MUL_EN selects
// single-cycle multiplies inside mdu_seq.
import defs::*;

module hazard_ctrl #(
   parameter int unsigned MUL_CYCLES = 4,
   parameter int unsigned DIV_CYCLES = 33
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] d_rs1,
   input  logic [4:0] d_rs2,
   input  logic [4:0] e_rd,
   input  logic       e_l,
   input  logic       e_m,
   input  logic [2:0] e_func3,
   input  logic       redirect,
   input  logic       mem_wait,
   output logic [4:0] stalls,
   output logic [4:0] flushes,
   output logic       mdu_start,
   output logic       mdu_done
);

   logic busy;
   logic load_use;

   mdu_seq #(
      .MUL_CYCLES (MUL_CYCLES),
      .DIV_CYCLES (DIV_CYCLES)
   ) u_mdu_seq (
      .clk       (clk),
      .rst_n     (rst_n),
      .e_m       (e_m),
      .e_func3   (e_func3),
      .redirect  (redirect),
      .mem_wait  (mem_wait),
      .busy      (busy),
      .mdu_start (mdu_start),
      .mdu_done  (mdu_done)
   );

   assign load_use = e_l && (e_rd != '0) && ((e_rd == d_rs1) || (e_rd == d_rs2));

   // Priority merge: redirect alone; else memory wait OR M-busy; else load-use
   always_comb begin
      stalls  = '0;
      flushes = '0;
      if (redirect) begin
         flushes[F] = 1'b1;
         flushes[D] = 1'b1;
      end else begin
         if (mem_wait) begin
            stalls[F]  = 1'b1;
            stalls[D]  = 1'b1;
            stalls[E]  = 1'b1;
            stalls[M]  = 1'b1;
            flushes[M] = 1'b1;
         end
         if (busy) begin
            stalls[F]  = 1'b1;
            stalls[D]  = 1'b1;
            flushes[E] = 1'b1;
         end
         if (!mem_wait && !busy && load_use) begin
            stalls[F]  = 1'b1;
            flushes[D] = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a reference model.
// Honours HAZARD_FAST_MUL_EN for the multiply expectations.
module tb_hazard_ctrl;

   localparam int unsigned MULC = 4;
   localparam int unsigned DIVC = 33;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] d_rs1, d_rs2, e_rd;
   logic       e_l, e_m, redirect, mem_wait;
   logic [2:0] e_func3;
   logic [4:0] stalls, flushes;
   logic       mdu_start, mdu_done;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(
      .MUL_CYCLES (MULC),
      .DIV_CYCLES (DIVC)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .d_rs1     (d_rs1),
      .d_rs2     (d_rs2),
      .e_rd      (e_rd),
      .e_l       (e_l),
      .e_m       (e_m),
      .e_func3   (e_func3),
      .redirect  (redirect),
      .mem_wait  (mem_wait),
      .stalls    (stalls),
      .flushes   (flushes),
      .mdu_start (mdu_start),
      .mdu_done  (mdu_done)
   );

   typedef struct {
      logic [4:0] rs1, rs2, rd;
      logic       l, rdr, mw;
      logic [4:0] es, ef;
   } vec_t;

   vec_t vecs[11];

`ifdef HAZARD_FAST_MUL_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   // Reference model: an op is "active" with an age in cycles since start
   bit          m_active;
   int unsigned m_age, m_lat;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [4:0] es, input logic [4:0] ef,
                      input logic est, input logic edn);
      logic [11:0] act, exp;
      #2;
      act = {stalls, flushes, mdu_start, mdu_done};
      exp = {es, ef, est, edn};
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @%0t: got stalls=%b flushes=%b start=%b done=%b, expected stalls=%b flushes=%b start=%b done=%b",
                  nm, $time, stalls, flushes, mdu_start, mdu_done, es, ef, est, edn);
      end
   endtask

   task automatic set_idle_inputs();
      d_rs1 = '0; d_rs2 = '0; e_rd = '0; e_l = 0; e_m = 0;
      e_func3 = '0; redirect = 0; mem_wait = 0;
   endtask

   // Computes this cycle's expected outputs from the rules and advances the model
   task automatic model(output logic [4:0] es, output logic [4:0] ef,
                        output logic est, output logic edn);
      bit b, lu;
      b = 0; est = 0; edn = 0;
      if (m_active) begin
         if (redirect && e_m) m_active = 0;
         else begin
            b = (m_age < m_lat);
            if (!b && !mem_wait) begin
               edn = 1; m_active = 0;
            end
            m_age++;
         end
      end else if (e_m && !redirect) begin
         est = 1;
         if (FAST && !e_func3[2]) edn = 1;
         else begin
            b = 1; m_active = 1; m_age = 1;
            m_lat = e_func3[2] ? DIVC : MULC;
         end
      end
      lu = e_l && e_rd != 0 && (e_rd == d_rs1 || e_rd == d_rs2);
      if (redirect) begin
         es = 5'b00000; ef = 5'b00011;
      end else begin
         es = (mem_wait ? 5'b01111 : 5'b0) | (b ? 5'b00011 : 5'b0);
         ef = (mem_wait ? 5'b01000 : 5'b0) | (b ? 5'b00100 : 5'b0);
         if (!mem_wait && !b && lu) begin
            es = 5'b00001; ef = 5'b00010;
         end
      end
   endtask

   initial begin
      logic [4:0] es, ef;
      logic       est, edn;
      bit         bz;

      vecs[0]  = '{5'd0,  5'd5,  5'd5,  1, 0, 0, 5'b00001, 5'b00010};
      vecs[1]  = '{5'd0,  5'd0,  5'd0,  1, 0, 0, 5'b00000, 5'b00000};
      vecs[2]  = '{5'd7,  5'd1,  5'd7,  1, 0, 0, 5'b00001, 5'b00010};
      vecs[3]  = '{5'd7,  5'd1,  5'd7,  0, 0, 0, 5'b00000, 5'b00000};
      vecs[4]  = '{5'd6,  5'd8,  5'd7,  1, 0, 0, 5'b00000, 5'b00000};
      vecs[5]  = '{5'd0,  5'd0,  5'd0,  0, 1, 0, 5'b00000, 5'b00011};
      vecs[6]  = '{5'd0,  5'd5,  5'd5,  1, 1, 0, 5'b00000, 5'b00011};
      vecs[7]  = '{5'd0,  5'd0,  5'd0,  0, 0, 1, 5'b01111, 5'b01000};
      vecs[8]  = '{5'd5,  5'd0,  5'd5,  1, 0, 1, 5'b01111, 5'b01000};
      vecs[9]  = '{5'd0,  5'd0,  5'd0,  0, 1, 1, 5'b00000, 5'b00011};
      vecs[10] = '{5'd3,  5'd31, 5'd31, 1, 0, 0, 5'b00001, 5'b00010};

      // Reset state
      set_idle_inputs();
      rst_n = 0;
      #3;
      chk("reset", '0, '0, 0, 0);
      tick();
      tick();
      rst_n = 1;

      // Directed combinational vectors from an idle FSM
      foreach (vecs[i]) begin
         tick();
         d_rs1 = vecs[i].rs1; d_rs2 = vecs[i].rs2; e_rd = vecs[i].rd;
         e_l = vecs[i].l; redirect = vecs[i].rdr; mem_wait = vecs[i].mw;
         chk($sformatf("vec%0d", i), vecs[i].es, vecs[i].ef, 0, 0);
      end
      tick();
      set_idle_inputs();
      chk("vec_clear", '0, '0, 0, 0);

      // Two back-to-back divides with e_m held
      for (int c = 0; c <= 68; c++) begin
         tick();
         e_m = (c <= 67); e_func3 = 3'b100;
         bz = (c <= 32) || (c >= 34 && c <= 66);
         chk($sformatf("div2 c%0d", c), bz ? 5'b00011 : 5'b0, bz ? 5'b00100 : 5'b0,
             (c == 0 || c == 34), (c == 33 || c == 67));
      end

      // Divide with memory wait across the end of the busy window
      for (int c = 0; c <= 42; c++) begin
         tick();
         e_m = (c <= 41); e_func3 = 3'b101;
         mem_wait = (c >= 30 && c <= 40);
         es = (c <= 32 ? 5'b00011 : 5'b0) | (mem_wait ? 5'b01111 : 5'b0);
         ef = (c <= 32 ? 5'b00100 : 5'b0) | (mem_wait ? 5'b01000 : 5'b0);
         chk($sformatf("divwait c%0d", c), es, ef, (c == 0), (c == 41));
      end

      // Asynchronous reset in the middle of a divide
      for (int c = 0; c < 10; c++) begin
         tick();
         e_m = 1; e_func3 = 3'b110; mem_wait = 0;
         chk($sformatf("rst_pre c%0d", c), 5'b00011, 5'b00100, (c == 0), 0);
      end
      tick();
      rst_n = 0; e_m = 0;
      #1 chk("rst_async_zero", '0, '0, 0, 0);
      e_m = 1;
      #1 chk("rst_idle_state", 5'b00011, 5'b00100, 1, 0);
      e_m = 0;
      tick();
      tick();
      rst_n = 1;
      for (int c = 0; c < 5; c++) begin
         tick();
         chk($sformatf("rst_post c%0d", c), '0, '0, 0, 0);
      end

      // Single multiply
      for (int c = 0; c <= 5; c++) begin
         tick();
         e_func3 = 3'b000;
         if (FAST) begin
            e_m = (c == 0);
            chk($sformatf("mulfast c%0d", c), '0, '0, (c == 0), (c == 0));
         end else begin
            e_m = (c <= 4);
            chk($sformatf("mul c%0d", c), (c <= 3) ? 5'b00011 : 5'b0,
                (c <= 3) ? 5'b00100 : 5'b0, (c == 0), (c == 4));
         end
      end

      // Randomized traffic against the reference model
      m_active = 0; m_age = 0; m_lat = 0;
      for (int n = 0; n < 3000; n++) begin
         tick();
         d_rs1    = 5'($urandom_range(0, 3));
         d_rs2    = 5'($urandom_range(0, 3));
         e_rd     = 5'($urandom_range(0, 3));
         e_l      = ($urandom_range(0, 2) == 0);
         e_m      = ($urandom_range(0, 3) != 0);
         e_func3  = 3'($urandom);
         redirect = ($urandom_range(0, 15) == 0);
         mem_wait = ($urandom_range(0, 5) == 0);
         model(es, ef, est, edn);
         chk($sformatf("rand%0d", n), es, ef, est, edn);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
